// File: rtl/orb_pkg.sv
// Shared orbital-frame definitions: word/address widths, sync word, serializer states.
// Reused by the packer-side blocks as well as the frame serializer.
package orb_pkg;

  localparam int ORB_WORD_W    = 12;
  localparam int ORB_ADDR_W    = 11;
  localparam int ORB_BIT_CNT_W = 4;
  localparam logic [ORB_WORD_W-1:0] ORB_SYNC_WORD = 12'hF1E;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DRAIN = 2'd3
  } orb_state_e;

  // Modulo increment for frame addresses; works whether or not len is a power of two.
  function automatic int orb_wrap_inc(input int a, input int len);
    return (a >= len - 1) ? 0 : a + 1;
  endfunction

endpackage

// File: rtl/orb_frame_serializer_if.sv
// Frame RAM read port plus serial line side of the orbital-word serializer.
interface orb_frame_serializer_if
  import orb_pkg::*;
#(
  parameter int ADDR_W = ORB_ADDR_W,
  parameter int WORD_W = ORB_WORD_W
);
  logic              en;
  logic [ADDR_W-1:0] rdAddr;
  logic [WORD_W-1:0] rdData;
  logic              sOut;
  logic              bitStb;
  logic              wordStb;
  logic              frameStb;
  logic              busy;

  modport slave (
    input  en, rdData,
    output rdAddr, sOut, bitStb, wordStb, frameStb, busy
  );

  modport master (
    output en, rdData,
    input  rdAddr, sOut, bitStb, wordStb, frameStb, busy
  );
endinterface

// File: rtl/orb_bit_timer.sv
// Bit-period divider: divCnt runs 0..BIT_DIV-1 while enabled, bitStb marks divCnt==0.
module orb_bit_timer #(
  parameter int BIT_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_bit_stb,
  output logic o_bit_start,
  output logic o_bit_end
);
  localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(BIT_DIV - 1);

  logic [DW-1:0] r_div_cnt;

  assign o_bit_start = i_en && !i_clr && (r_div_cnt == '0);
  assign o_bit_end   = i_en && !i_clr && (r_div_cnt == DIV_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt <= '0;
      o_bit_stb <= 1'b0;
    end else begin
      o_bit_stb <= o_bit_start;
      if (i_clr)
        r_div_cnt <= '0;
      else if (i_en)
        r_div_cnt <= (r_div_cnt == DIV_MAX) ? '0 : r_div_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/orb_frame_serializer.sv
// Walks the frame RAM and shifts 12-bit words out MSB first at a fixed bit rate,
// substituting SYNC_WORD for address 0 and prefetching the next word into a holding reg.
module orb_frame_serializer
  import orb_pkg::*;
#(
  parameter int ADDR_W    = ORB_ADDR_W,
  parameter int WORD_W    = ORB_WORD_W,
  parameter int FRAME_LEN = 2048,
  parameter int BIT_DIV   = 16,
  parameter logic [WORD_W-1:0] SYNC_WORD = WORD_W'(ORB_SYNC_WORD)
) (
  input logic clk,
  input logic rst,
  orb_frame_serializer_if.slave bus
);
  localparam int FETCH_LAT = 2;
  localparam logic [ORB_BIT_CNT_W-1:0] BIT_TOP = ORB_BIT_CNT_W'(WORD_W - 1);

  logic                     r_en_s1, r_en_s, r_en_s_d;
  orb_state_e               r_state, w_state_nxt;
  logic                     r_prime_cnt;
  logic [ADDR_W-1:0]        r_rd_addr;
  logic [FETCH_LAT-1:0]     r_vld_pipe;
  logic [WORD_W-1:0]        r_hold, r_shift;
  logic                     r_hold_sync, r_shift_sync;
  logic [ORB_BIT_CNT_W-1:0] r_bit_cnt;
  logic                     r_sout, r_word_stb, r_frame_stb;

  logic w_bit_stb, w_bit_start, w_bit_end;
  logic w_en_rise, w_run, w_timer_clr, w_start, w_prime_load, w_prime_xfer;
  logic w_last_bit, w_advance, w_xfer, w_word_first;

  // Synchroniser resets high so an en already asserted at reset release is not a new edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) {r_en_s1, r_en_s, r_en_s_d} <= 3'b111;
    else      {r_en_s1, r_en_s, r_en_s_d} <= {bus.en, r_en_s1, r_en_s};
  end

  assign w_en_rise = r_en_s && !r_en_s_d;

  orb_bit_timer #(.BIT_DIV(BIT_DIV)) u_bit_timer (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_timer_clr),
    .i_en        (w_run),
    .o_bit_stb   (w_bit_stb),
    .o_bit_start (w_bit_start),
    .o_bit_end   (w_bit_end)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_en_rise)   w_state_nxt = ST_PRIME;
      ST_PRIME: if (r_prime_cnt) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (!r_en_s)     w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_last_bit)  w_state_nxt = ST_IDLE;
      default:                   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_run        = (r_state == ST_SHIFT) || (r_state == ST_DRAIN);
    w_timer_clr  = !w_run;
    w_start      = (r_state == ST_IDLE) && w_en_rise;
    w_prime_load = (r_state == ST_PRIME) && !r_prime_cnt;
    w_prime_xfer = (r_state == ST_PRIME) && r_prime_cnt;
    w_last_bit   = w_run && w_bit_end && (r_bit_cnt == '0);
    w_advance    = (r_state == ST_SHIFT) && w_last_bit;
    w_xfer       = w_prime_xfer || w_advance;
    w_word_first = w_run && w_bit_start && (r_bit_cnt == BIT_TOP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_prime_cnt <= 1'b0;
    else      r_prime_cnt <= (r_state == ST_PRIME) && !r_prime_cnt;
  end

  // Every address change opens a fetch; rdData is captured FETCH_LAT clk later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_addr   <= '0;
      r_vld_pipe  <= '0;
      r_hold      <= '0;
      r_hold_sync <= 1'b0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[FETCH_LAT-2:0], w_prime_load || w_advance};
      if (w_start)
        r_rd_addr <= '0;
      else if (w_prime_load || w_advance)
        r_rd_addr <= ADDR_W'(orb_wrap_inc(int'(r_rd_addr), FRAME_LEN));

      if (w_prime_load) begin
        r_hold      <= SYNC_WORD;
        r_hold_sync <= 1'b1;
      end else if (r_vld_pipe[FETCH_LAT-1]) begin
        r_hold      <= (r_rd_addr == '0) ? SYNC_WORD : bus.rdData;
        r_hold_sync <= (r_rd_addr == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift      <= '0;
      r_shift_sync <= 1'b0;
      r_bit_cnt    <= '0;
    end else if (w_xfer) begin
      r_shift      <= r_hold;
      r_shift_sync <= r_hold_sync;
      r_bit_cnt    <= BIT_TOP;
    end else if (w_run && w_bit_end) begin
      r_shift <= {r_shift[WORD_W-2:0], 1'b0};
      if (r_bit_cnt != '0) r_bit_cnt <= r_bit_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sout      <= 1'b0;
      r_word_stb  <= 1'b0;
      r_frame_stb <= 1'b0;
    end else begin
      if (w_run && w_bit_start)  r_sout <= r_shift[WORD_W-1];
      else if (r_state == ST_IDLE) r_sout <= 1'b0;
      r_word_stb  <= w_word_first;
      r_frame_stb <= w_word_first && r_shift_sync;
    end
  end

  assign bus.rdAddr   = r_rd_addr;
  assign bus.sOut     = r_sout;
  assign bus.bitStb   = w_bit_stb;
  assign bus.wordStb  = r_word_stb;
  assign bus.frameStb = r_frame_stb;
  assign bus.busy     = (r_state != ST_IDLE);
endmodule

// File: tb/tb_orb_frame_serializer.sv
// Bench for orb_frame_serializer: short frame (8 words), 4 clk per bit, RAM model that
// drives valid data only in the 1-clk window after each address change.
module tb_orb_frame_serializer;
  localparam int AW = 11;
  localparam int WW = 12;
  localparam int FL = 8;
  localparam int BD = 4;
  localparam logic [WW-1:0] SYNC = 12'hF1E;

  typedef struct {
    int drop_word;
    int drop_bit;
    int exp_bits;
  } drop_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  orb_frame_serializer_if #(.ADDR_W(AW), .WORD_W(WW)) bus();

  orb_frame_serializer #(
    .ADDR_W(AW), .WORD_W(WW), .FRAME_LEN(FL), .BIT_DIV(BD), .SYNC_WORD(SYNC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit            ram_rand = 1'b0;
  logic [WW-1:0] rand_mem [FL];
  logic [AW-1:0] last_addr = '0;

  function automatic logic [WW-1:0] ram_word(input int a);
    if (ram_rand) return rand_mem[a % FL];
    return WW'(a);
  endfunction

  // Word number i of a run comes from frame address i mod FL; address 0 carries sync.
  function automatic logic [WW-1:0] exp_word(input int i);
    int a;
    a = i % FL;
    return (a == 0) ? SYNC : ram_word(a);
  endfunction

  // Synchronous RAM: data valid one clk after an address change, noise otherwise.
  always @(posedge clk) begin
    if (bus.rdAddr != last_addr) bus.rdData <= ram_word(int'(bus.rdAddr));
    else                         bus.rdData <= WW'($urandom);
    last_addr <= bus.rdAddr;
  end

  int   cyc = 0;
  int   stray = 0;
  int   idle_viol = 0;
  bit   idle_watch = 1'b0;
  logic bit_q [$];
  logic ws_q  [$];
  logic fs_q  [$];
  int   cyc_q [$];

  always @(negedge clk) begin
    cyc++;
    if (bus.bitStb === 1'b1) begin
      bit_q.push_back(bus.sOut);
      ws_q.push_back(bus.wordStb);
      fs_q.push_back(bus.frameStb);
      cyc_q.push_back(cyc);
    end else if (bus.wordStb !== 1'b0 || bus.frameStb !== 1'b0) begin
      stray++;
    end
    if (idle_watch && (bus.sOut !== 1'b0 || bus.busy !== 1'b0 || bus.rdAddr !== '0 ||
                       bus.bitStb !== 1'b0 || bus.wordStb !== 1'b0 || bus.frameStb !== 1'b0))
      idle_viol++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    bit_q.delete();
    ws_q.delete();
    fs_q.delete();
    cyc_q.delete();
  endtask

  task automatic wait_bits(input int n, input string name);
    int t;
    t = 0;
    while (bit_q.size() < n && t < 20000) begin
      tick(1);
      t++;
    end
    if (bit_q.size() < n) chk({name, " bit timeout"}, bit_q.size(), n);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (bus.busy === 1'b1 && t < 2000) begin
      tick(1);
      t++;
    end
    tick(2);
    chk({name, " busy after drain"}, bus.busy, 1'b0);
    chk({name, " sOut after drain"}, bus.sOut, 1'b0);
  endtask

  task automatic check_stream(input string name, input int exp_bits);
    int nb, ws_err, fs_err, gap_err, fr_err, last_fr;
    logic [WW-1:0] got;
    nb = bit_q.size();
    ws_err = 0; fs_err = 0; gap_err = 0; fr_err = 0; last_fr = -1;
    chk({name, " bit count"}, nb, exp_bits);
    for (int w = 0; w < nb / WW; w++) begin
      got = '0;
      for (int b = 0; b < WW; b++) got = {got[WW-2:0], bit_q[w*WW + b]};
      chk($sformatf("%s word%0d", name, w), got, exp_word(w));
    end
    for (int i = 0; i < nb; i++) begin
      if (ws_q[i] !== ((i % WW) == 0)) ws_err++;
      if (fs_q[i] !== (((i % WW) == 0) && (((i / WW) % FL) == 0))) fs_err++;
      if (i > 0 && (cyc_q[i] - cyc_q[i-1]) != BD) gap_err++;
      if (fs_q[i] === 1'b1) begin
        if (last_fr >= 0 && (cyc_q[i] - last_fr) != FL*WW*BD) fr_err++;
        last_fr = cyc_q[i];
      end
    end
    chk({name, " wordStb placement errs"}, ws_err, 0);
    chk({name, " frameStb placement errs"}, fs_err, 0);
    chk({name, " bit period errs"}, gap_err, 0);
    chk({name, " frame period errs"}, fr_err, 0);
  endtask

  initial begin
    drop_t tbl [5];
    int    en_cyc, k;
    string nm;

    tbl[0] = '{0, 5, 12};
    tbl[1] = '{2, 5, 36};
    tbl[2] = '{3, 5, 48};
    tbl[3] = '{1, 10, 24};
    tbl[4] = '{4, 1, 60};

    bus.en = 1'b0;
    rst    = 1'b0;
    tick(3);
    chk("reset sOut", bus.sOut, 1'b0);
    chk("reset busy", bus.busy, 1'b0);
    chk("reset rdAddr", bus.rdAddr, 0);
    chk("reset strobes", {bus.bitStb, bus.wordStb, bus.frameStb}, 3'b000);
    rst = 1'b1;
    idle_watch = 1'b1;
    tick(100);
    idle_watch = 1'b0;
    chk("idle 100clk violations", idle_viol, 0);

    // Long run over the frame wrap, address n holds n.
    clear_mon();
    ram_rand = 1'b0;
    bus.en = 1'b1;
    en_cyc = cyc;
    wait_bits(2*FL*WW + 30, "run");
    bus.en = 1'b0;
    wait_idle("run");
    chk("run first bitStb latency", (cyc_q.size() > 0) ? cyc_q[0] - en_cyc : -1, 6);
    check_stream("run", 19*WW);
    tick(5);

    foreach (tbl[i]) begin
      nm = $sformatf("drop w%0d b%0d", tbl[i].drop_word, tbl[i].drop_bit);
      clear_mon();
      bus.en = 1'b1;
      wait_bits(tbl[i].drop_word*WW + tbl[i].drop_bit, nm);
      bus.en = 1'b0;
      wait_idle(nm);
      check_stream(nm, tbl[i].exp_bits);
      tick(5);
    end

    // en pulse that dies while priming still yields one full word.
    clear_mon();
    bus.en = 1'b1;
    tick(3);
    bus.en = 1'b0;
    wait_bits(1, "prime glitch");
    wait_idle("prime glitch");
    check_stream("prime glitch", WW);
    tick(5);

    // Random RAM contents over three frames plus a random drop point.
    ram_rand = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int a = 0; a < FL; a++) rand_mem[a] = WW'($urandom);
      k = 3*FL*WW + WW*$urandom_range(0, 3) + $urandom_range(1, 10);
      nm = $sformatf("rand%0d", r);
      clear_mon();
      bus.en = 1'b1;
      wait_bits(k, nm);
      bus.en = 1'b0;
      wait_idle(nm);
      check_stream(nm, (k / WW + 1) * WW);
      tick(5);
    end
    ram_rand = 1'b0;

    // Reset mid-word 2 with en held high: immediate abort, no restart until en re-rises.
    clear_mon();
    bus.en = 1'b1;
    wait_bits(WW + 4, "rst mid");
    rst = 1'b0;
    #1;
    chk("rst mid sOut", bus.sOut, 1'b0);
    chk("rst mid busy", bus.busy, 1'b0);
    chk("rst mid rdAddr", bus.rdAddr, 0);
    chk("rst mid strobes", {bus.bitStb, bus.wordStb, bus.frameStb}, 3'b000);
    tick(3);
    rst = 1'b1;
    clear_mon();
    tick(40);
    chk("rst release no restart bits", bit_q.size(), 0);
    chk("rst release busy", bus.busy, 1'b0);
    bus.en = 1'b0;
    tick(5);
    clear_mon();
    bus.en = 1'b1;
    wait_bits(WW + 5, "rst restart");
    bus.en = 1'b0;
    wait_idle("rst restart");
    check_stream("rst restart", 2*WW);

    chk("stray strobes", stray, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
